// File: rtl/dilated_tap_buffer.sv
// dilated_tap_buffer: ring-buffer history of the last DILATION samples, presenting
// {x[t-DILATION], x[t]} to a dot-product engine over a valid/ready handshake.
module dilated_tap_buffer #(
    parameter int W        = 16,
    parameter int DILATION = 4
) (
    input  logic                clk,
    input  logic                rst,
    input  logic signed [W-1:0] in_data [0:3],
    input  logic                in_v,
    output logic                in_ready,
    output logic signed [W-1:0] a [0:7],
    output logic                a_v,
    input  logic                a_ready
);
    localparam int AW = DILATION > 1 ? $clog2(DILATION) : 1;
    localparam int FW = $clog2(DILATION + 1);
    typedef enum logic [1:0] {ACCEPT, LOOKUP, PRESENT} state_t;
    state_t              state;
    logic [AW-1:0]       wptr;
    logic [FW-1:0]       fill;
    logic signed [W-1:0] cur [0:3];
    logic [4*W-1:0]      mem [DILATION];
    logic                full;
    assign in_ready = state == ACCEPT;
    assign full     = fill == FW'(DILATION);
    // history is not reset; fill gates every read until it has been rewritten
    always_ff @(posedge clk)
        if (state == LOOKUP) mem[wptr] <= {cur[3], cur[2], cur[1], cur[0]};
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= ACCEPT;
            wptr  <= '0;
            fill  <= '0;
            a_v   <= 1'b0;
            for (int i = 0; i < 4; i++) cur[i] <= '0;
            for (int i = 0; i < 8; i++) a[i] <= '0;
        end else begin
            case (state)
                ACCEPT: if (in_v) begin
                    for (int i = 0; i < 4; i++) cur[i] <= in_data[i];
                    state <= LOOKUP;
                end
                LOOKUP: begin
                    for (int i = 0; i < 4; i++) begin
                        a[i]   <= full ? mem[wptr][i*W +: W] : '0;
                        a[i+4] <= cur[i];
                    end
                    wptr  <= DILATION == 1 ? '0 : wptr + 1'b1;
                    fill  <= full ? fill : fill + 1'b1;
                    a_v   <= 1'b1;
                    state <= PRESENT;
                end
                PRESENT: if (a_ready) begin
                    a_v   <= 1'b0;
                    state <= ACCEPT;
                end
                default: state <= ACCEPT;
            endcase
        end
    end
endmodule

// File: tb/tb_dilated_tap_buffer.sv
// tb_dilated_tap_buffer: DILATION=4 and DILATION=1 instances driven in lockstep and
// checked against a sample-history queue model.
module tb_dilated_tap_buffer;
    logic clk = 1'b0, rst = 1'b1, in_v = 1'b0, a_ready = 1'b0;
    logic signed [15:0] in_data [0:3];
    logic rdy4, rdy1, av4, av1;
    logic signed [15:0] a4 [0:7];
    logic signed [15:0] a1 [0:7];
    logic [127:0] v4, v1;
    logic [63:0] hist [$];
    int n_cmp = 0, n_bad = 0;

    always #5 clk = ~clk;

    dilated_tap_buffer #(.W(16), .DILATION(4)) u4 (
        .clk(clk), .rst(rst), .in_data(in_data), .in_v(in_v), .in_ready(rdy4),
        .a(a4), .a_v(av4), .a_ready(a_ready));
    dilated_tap_buffer #(.W(16), .DILATION(1)) u1 (
        .clk(clk), .rst(rst), .in_data(in_data), .in_v(in_v), .in_ready(rdy1),
        .a(a1), .a_v(av1), .a_ready(a_ready));

    for (genvar g = 0; g < 8; g++) begin : pk
        assign v4[g*16 +: 16] = a4[g];
        assign v1[g*16 +: 16] = a1[g];
    end

    task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic set_in(input logic [63:0] s);
        for (int c = 0; c < 4; c++) in_data[c] = s[c*16 +: 16];
    endtask

    // the sample accepted d steps before the newest one, or zero padding
    function automatic logic [63:0] tap(input int d);
        int k = hist.size() - 1;
        return k >= d ? hist[k-d] : 64'h0;
    endfunction

    task automatic do_reset();
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        hist.delete();
    endtask

    task automatic xfer(input logic [63:0] s, input int hold, input bit release_it);
        logic [127:0] e4, e1;
        int n = 0;
        set_in(s);
        in_v = 1'b1;
        while (!rdy4 && n < 20) begin
            @(negedge clk);
            n++;
        end
        check("accept_ready", 128'(rdy4), 128'd1);
        hist.push_back(s);
        e4 = {s, tap(4)};
        e1 = {s, tap(1)};
        @(negedge clk);
        in_v = 1'($urandom_range(0, 1));
        set_in({$urandom, $urandom});
        check("lookup_flags", 128'({rdy4, rdy1, av4, av1}), 128'h0);
        @(negedge clk);
        check("av_rise", 128'({rdy4, rdy1, av4, av1}), 128'h3);
        check("a_d4", v4, e4);
        check("a_d1", v1, e1);
        for (int i = 0; i < hold; i++) begin
            in_v = 1'b1;
            set_in({$urandom, $urandom});
            @(negedge clk);
            check("bp_flags", 128'({rdy4, rdy1, av4, av1}), 128'h3);
            check("bp_a4", v4, e4);
            check("bp_a1", v1, e1);
        end
        if (release_it) begin
            a_ready = 1'b1;
            @(negedge clk);
            a_ready = 1'b0;
            check("release", 128'({rdy4, rdy1, av4, av1}), 128'hC);
        end
    endtask

    initial begin
        set_in(64'h0);
        repeat (2) @(negedge clk);
        check("rst_flags", 128'({rdy4, rdy1, av4, av1}), 128'hC);
        check("rst_a4", v4, 128'h0);
        check("rst_a1", v1, 128'h0);
        rst = 1'b0;
        @(negedge clk);
        check("post_rst_rdy", 128'({rdy4, rdy1, av4, av1}), 128'hC);
        for (int k = 0; k < 13; k++)
            xfer({16'(16*k+3), 16'(16*k+2), 16'(16*k+1), 16'(16*k)}, 0, 1);
        for (int k = 0; k < 3; k++) xfer({$urandom, $urandom}, 10, 1);
        for (int k = 0; k < 20; k++) xfer({$urandom, $urandom}, int'($urandom_range(0, 3)), 1);
        do_reset();
        for (int k = 0; k < 6; k++) xfer({$urandom, $urandom}, 0, 1);
        xfer({$urandom, $urandom}, 2, 0);
        #2 rst = 1'b1;
        #1;
        check("rst_mid_flags", 128'({rdy4, rdy1, av4, av1}), 128'hC);
        check("rst_mid_a4", v4, 128'h0);
        check("rst_mid_a1", v1, 128'h0);
        in_v = 1'b0;
        @(negedge clk);
        rst = 1'b0;
        hist.delete();
        for (int k = 0; k < 6; k++)
            xfer({16'h7FFF, 16'h8000, 16'(16'hFFFF - k), 16'(k)}, k % 2, 1);
        do_reset();
        in_v = 1'b1;
        a_ready = 1'b1;
        set_in({$urandom, $urandom});
        for (int i = 0; i < 30; i++) begin
            check("tput_rdy", 128'({rdy4, rdy1}), i % 3 == 0 ? 128'h3 : 128'h0);
            @(negedge clk);
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end
endmodule
